// File: rtl/chess_pkg.sv
// Shared board definitions: piece codes, square/piece widths, controller
// states and the initial-position lookup.
package chess_pkg;

    localparam int unsigned SQ_W       = 6;
    localparam int unsigned PIECE_W    = 4;
    localparam int unsigned TYPE_W     = 3;
    localparam int unsigned COLOUR_BIT = 3;

    // Piece type field, bits [2:0] of a piece code; 7 is reserved.
    localparam logic [TYPE_W-1:0] EMPTY  = 3'd0;
    localparam logic [TYPE_W-1:0] PAWN   = 3'd1;
    localparam logic [TYPE_W-1:0] KNIGHT = 3'd2;
    localparam logic [TYPE_W-1:0] BISHOP = 3'd3;
    localparam logic [TYPE_W-1:0] ROOK   = 3'd4;
    localparam logic [TYPE_W-1:0] QUEEN  = 3'd5;
    localparam logic [TYPE_W-1:0] KING   = 3'd6;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StMvClr,
        StMvSet
    } state_e;

    // Initial-position code for square {row, col}. Colour bit is set for the
    // side starting on rows 0-1; empty squares are all-zero.
    function automatic logic [PIECE_W-1:0] init_piece(input logic [SQ_W-1:0] addr);
        logic [2:0]        row;
        logic [2:0]        col;
        logic [TYPE_W-1:0] kind;
        row  = addr[5:3];
        col  = addr[2:0];
        kind = EMPTY;
        case (row)
            3'd0, 3'd7: begin
                case (col)
                    3'd0, 3'd7: kind = ROOK;
                    3'd1, 3'd6: kind = KNIGHT;
                    3'd2, 3'd5: kind = BISHOP;
                    3'd3:       kind = QUEEN;
                    default:    kind = KING;
                endcase
            end
            3'd1, 3'd6: kind = PAWN;
            default:    kind = EMPTY;
        endcase
        if (kind == EMPTY) begin
            return '0;
        end
        return {(row < 3'd2), kind};
    endfunction

endpackage

// File: rtl/board_controller_if.sv
// Request bundle into the board controller: two-phase move requests from the
// logic unit and single-square writes, each with a valid/ready handshake.
interface board_controller_if;
    import chess_pkg::*;

    logic               mv_valid;
    logic               mv_ready;
    logic [SQ_W-1:0]    mv_src;
    logic [SQ_W-1:0]    mv_dst;
    logic [PIECE_W-1:0] mv_piece;

    logic               wr_valid;
    logic               wr_ready;
    logic [SQ_W-1:0]    wr_addr;
    logic [PIECE_W-1:0] wr_piece;

    modport master (
        output mv_valid, mv_src, mv_dst, mv_piece,
        output wr_valid, wr_addr, wr_piece,
        input  mv_ready, wr_ready
    );

    modport slave (
        input  mv_valid, mv_src, mv_dst, mv_piece,
        input  wr_valid, wr_addr, wr_piece,
        output mv_ready, wr_ready
    );

endinterface

// File: rtl/board_init_rom.sv
// Combinational initial-position ROM: square address to piece code.
module board_init_rom
    import chess_pkg::*;
(
    input  logic [SQ_W-1:0]    addr,
    output logic [PIECE_W-1:0] piece
);

    assign piece = init_piece(addr);

endmodule

// File: rtl/board_controller.sv
// Board storage owner: arbitrates the initial-position loader, two-phase move
// commits and single-square writes onto one write port, and exports the
// flattened board with status pulses and a completed-move counter.
module board_controller
    import chess_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter bit          AUTO_LOAD = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_req,
    board_controller_if.slave  bus,
    output logic [255:0]       board_flat,
    output logic               busy,
    output logic               load_done,
    output logic               mv_done,
    output logic               wr_done,
    output logic [CNT_W-1:0]   move_count
);

    localparam int unsigned BOARD_W    = 64 * PIECE_W;
    localparam state_e      ResetState = state_e'(AUTO_LOAD ? StLoad : StIdle);

    state_e             state_q;
    logic [SQ_W-1:0]    cnt_q;
    logic [SQ_W-1:0]    src_q;
    logic [SQ_W-1:0]    dst_q;
    logic [PIECE_W-1:0] piece_q;
    logic               init_pend_q;
    logic               idle_q;
    logic               busy_q;
    logic               load_done_q;
    logic               mv_done_q;
    logic               wr_done_q;
    logic [BOARD_W-1:0] board_q;
    logic [CNT_W-1:0]   count_q;

    logic [PIECE_W-1:0] rom_piece;
    logic               mv_accept;
    logic               wr_accept;
    logic               we;
    logic [SQ_W-1:0]    wa;
    logic [PIECE_W-1:0] wd;

    board_init_rom u_init_rom (
        .addr  (cnt_q),
        .piece (rom_piece)
    );

    // Handshake: idle_q is registered so ready stays low through reset even
    // when the controller resets straight into idle; init_req wins over both.
    always_comb begin
        bus.mv_ready = idle_q & ~init_req;
        bus.wr_ready = idle_q & ~init_req & ~bus.mv_valid;
    end

    assign mv_accept = bus.mv_valid & bus.mv_ready;
    assign wr_accept = bus.wr_valid & bus.wr_ready;

    // Single write port arbitration: the state decides who owns the port.
    always_comb begin
        we = 1'b0;
        wa = cnt_q;
        wd = rom_piece;
        unique case (state_q)
            StLoad: begin
                we = 1'b1;
                wa = cnt_q;
                wd = rom_piece;
            end
            StMvClr: begin
                we = 1'b1;
                wa = src_q;
                wd = '0;
            end
            StMvSet: begin
                we = 1'b1;
                wa = dst_q;
                wd = piece_q;
            end
            StIdle: begin
                if (wr_accept) begin
                    we = 1'b1;
                    wa = bus.wr_addr;
                    wd = bus.wr_piece;
                end
            end
            default: ;
        endcase
    end

    // Controller FSM with registered status outputs and the board write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ResetState;
            cnt_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            piece_q     <= '0;
            init_pend_q <= 1'b0;
            idle_q      <= 1'b0;
            busy_q      <= 1'b1;
            load_done_q <= 1'b0;
            mv_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            board_q     <= '0;
            count_q     <= '0;
        end else begin
            load_done_q <= 1'b0;
            mv_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            // Squares are 4 bits wide, so the bit offset is the address << 2.
            if (we) begin
                board_q[{wa, 2'b00} +: PIECE_W] <= wd;
            end
            unique case (state_q)
                StIdle: begin
                    idle_q <= 1'b1;
                    busy_q <= 1'b0;
                    if (init_req) begin
                        state_q <= StLoad;
                        cnt_q   <= '0;
                        idle_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (mv_accept) begin
                        src_q   <= bus.mv_src;
                        dst_q   <= bus.mv_dst;
                        piece_q <= bus.mv_piece;
                        state_q <= StMvClr;
                        idle_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (wr_accept) begin
                        wr_done_q <= 1'b1;
                    end
                end
                StLoad: begin
                    if (init_req) begin
                        cnt_q <= '0;
                    end else if (cnt_q == {SQ_W{1'b1}}) begin
                        load_done_q <= 1'b1;
                        count_q     <= '0;
                        state_q     <= StIdle;
                        idle_q      <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + SQ_W'(1);
                    end
                end
                StMvClr: begin
                    init_pend_q <= init_pend_q | init_req;
                    state_q     <= StMvSet;
                end
                StMvSet: begin
                    mv_done_q <= 1'b1;
                    count_q   <= count_q + CNT_W'(1);
                    // A reload requested mid-move starts once the move lands.
                    if (init_pend_q | init_req) begin
                        init_pend_q <= 1'b0;
                        state_q     <= StLoad;
                        cnt_q       <= '0;
                    end else begin
                        state_q <= StIdle;
                        idle_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign board_flat = board_q;
    assign busy       = busy_q;
    assign load_done  = load_done_q;
    assign mv_done    = mv_done_q;
    assign wr_done    = wr_done_q;
    assign move_count = count_q;

endmodule
